// File: rtl/ntt_butterfly_pipe_if.sv
// Operand/result bundle for the NTT butterfly pipeline.
// The master drives the operands and pipeline advance; the slave (the butterfly) returns results.
interface ntt_butterfly_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 8
) ();
  logic             en;
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] a_pair;
  logic [WIDTH-1:0] omega;
  logic [TAG_W-1:0] tag_in;
  logic [WIDTH-1:0] sum_out;
  logic [WIDTH-1:0] diff_out;
  logic [TAG_W-1:0] tag_out;
  logic             out_valid;
  logic             busy;

  modport master (
    output en, in_valid, mode, a, a_pair, omega, tag_in,
    input  sum_out, diff_out, tag_out, out_valid, busy
  );

  modport slave (
    input  en, in_valid, mode, a, a_pair, omega, tag_in,
    output sum_out, diff_out, tag_out, out_valid, busy
  );
endinterface

// File: rtl/ntt_butterfly_pipe.sv
// Five-stage Gentleman-Sande butterfly with Montgomery reduction.
// mode 0: sum = (a + a_pair) mod Q, diff = mont(omega * (a + 2Q - a_pair)).
// mode 1: sum = a_pair mod Q,       diff = mont(omega * a)  (pointwise multiply).
// Every register freezes while en is low; data registers load regardless of valid.
module ntt_butterfly_pipe #(
  parameter int WIDTH  = 16,
  parameter int Q      = 12289,
  parameter int R_BITS = 18,
  parameter int QINV   = 12287,
  parameter int TAG_W  = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  ntt_butterfly_pipe_if.slave bus
);

  // u = T + m*Q needs room for R_BITS of zeros plus a result below 2Q.
  localparam int UW = R_BITS + WIDTH + 1;
  localparam logic [WIDTH-1:0]  Q_W     = WIDTH'(Q);
  localparam logic [WIDTH-1:0]  TWO_Q_W = WIDTH'(2 * Q);
  localparam logic [R_BITS-1:0] QINV_R  = R_BITS'(QINV);
  localparam logic [UW-1:0]     Q_U     = UW'(Q);

  logic [WIDTH-1:0]   d_pre, s_pre, s_half, s_red;
  logic [WIDTH-1:0]   d1, w1, s1, s2, s3, s4;
  logic [TAG_W-1:0]   tag1, tag2, tag3, tag4;
  logic               v1, v2, v3, v4;
  logic [2*WIDTH-1:0] t_prod, t2, t3;
  logic [R_BITS-1:0]  m_prod, m3;
  logic [UW-1:0]      u_sum, u4, t_shift;

  // Pre-adders and the two-step conditional reduction of the sum path.
  always_comb begin
    d_pre = bus.a;
    s_pre = bus.a_pair;
    if (!bus.mode) begin
      d_pre = bus.a + TWO_Q_W - bus.a_pair;
      s_pre = bus.a + bus.a_pair;
    end
    s_half = (s_pre >= TWO_Q_W) ? s_pre - TWO_Q_W : s_pre;
    s_red  = (s_half >= Q_W) ? s_half - Q_W : s_half;
  end

  assign t_prod  = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, w1};
  assign m_prod  = t2[R_BITS-1:0] * QINV_R;
  assign u_sum   = {{(UW-2*WIDTH){1'b0}}, t3} + {{(UW-R_BITS){1'b0}}, m3} * Q_U;
  assign t_shift = u4 >> R_BITS;

  // Pipeline registers: pre-add, multiply, m, u, final correction with matched sideband delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0; w1 <= '0; s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
      tag1 <= '0; tag2 <= '0; tag3 <= '0; tag4 <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      t2 <= '0; t3 <= '0; m3 <= '0; u4 <= '0;
      bus.sum_out   <= '0;
      bus.diff_out  <= '0;
      bus.tag_out   <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.en) begin
      d1   <= d_pre;
      w1   <= bus.omega;
      s1   <= s_red;
      tag1 <= bus.tag_in;
      v1   <= bus.in_valid;

      t2   <= t_prod;
      s2   <= s1;
      tag2 <= tag1;
      v2   <= v1;

      t3   <= t2;
      m3   <= m_prod;
      s3   <= s2;
      tag3 <= tag2;
      v3   <= v2;

      u4   <= u_sum;
      s4   <= s3;
      tag4 <= tag3;
      v4   <= v3;

      bus.diff_out  <= WIDTH'((t_shift >= Q_U) ? t_shift - Q_U : t_shift);
      bus.sum_out   <= s4;
      bus.tag_out   <= tag4;
      bus.out_valid <= v4;
    end
  end

  // Anything still in flight or being presented keeps busy high.
  assign bus.busy = v1 | v2 | v3 | v4 | bus.out_valid;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Scoreboard bench for ntt_butterfly_pipe: driver pushes model results, negedge monitor pops and checks.
module tb_ntt_butterfly_pipe;
  localparam int W  = 16;
  localparam int TW = 8;
  localparam int Q  = 12289;
  localparam longint R = 64'd1 << 18;

  typedef struct {
    int sum;
    int diff;
    int tag;
    int edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   enabled_edges = 0;
  bit   last_en = 1'b0;
  bit   prev_ov = 1'b0;
  int   hold_sum, hold_diff, hold_tag;
  int   rinv;
  exp_t sbq[$];

  ntt_butterfly_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  ntt_butterfly_pipe #(.WIDTH(W), .Q(Q), .R_BITS(18), .QINV(12287), .TAG_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain modular arithmetic with R^-1 mod Q.
  function automatic void model(input int a, input int ap, input int w, input int md,
                                output int s, output int d);
    longint dd;
    s  = md ? (ap % Q) : ((a + ap) % Q);
    dd = md ? longint'(a) : longint'(a + 2 * Q - ap);
    d  = int'(((dd * w) % Q) * rinv % Q);
  endfunction

  always @(posedge clk) begin
    last_en = (reset_n === 1'b1) && (bus.en === 1'b1);
    if (last_en) enabled_edges++;
  end

  // Monitor: pops on each freshly loaded output, checks hold behaviour across stalls.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n !== 1'b1) begin
      prev_ov = 1'b0;
    end else begin
      if (!last_en) begin
        chk("stall_valid_hold", int'(bus.out_valid === 1'b1), int'(prev_ov));
        if (prev_ov) begin
          chk("stall_sum_hold", int'(bus.sum_out), hold_sum);
          chk("stall_diff_hold", int'(bus.diff_out), hold_diff);
          chk("stall_tag_hold", int'(bus.tag_out), hold_tag);
        end
      end else if (bus.out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sum_out", int'(bus.sum_out), e.sum);
          chk("diff_out", int'(bus.diff_out), e.diff);
          chk("tag_out", int'(bus.tag_out), e.tag);
          chk("latency_edges", enabled_edges, e.edge_n + 4);
        end
        hold_sum  = int'(bus.sum_out);
        hold_diff = int'(bus.diff_out);
        hold_tag  = int'(bus.tag_out);
      end
      prev_ov = (bus.out_valid === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_item(input int a, input int ap, input int w, input int md, input int tg,
                            input int es, input int ed);
    exp_t e;
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode     = md[0];
    bus.a        = W'(a);
    bus.a_pair   = W'(ap);
    bus.omega    = W'(w);
    bus.tag_in   = TW'(tg);
    e.sum = es; e.diff = ed; e.tag = tg & 8'hFF; e.edge_n = enabled_edges + 1;
    sbq.push_back(e);
    step();
  endtask

  task automatic send(input int a, input int ap, input int w, input int md, input int tg);
    int s, d;
    model(a, ap, w, md, s, d);
    drive_item(a, ap, w, md, tg, s, d);
  endtask

  task automatic send_rand(input int md);
    send(int'($urandom_range(0, 2 * Q - 1)), int'($urandom_range(0, 2 * Q - 1)),
         int'($urandom_range(0, Q - 1)), md, int'($urandom_range(0, 255)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.en       = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom_range(0, 2 * Q - 1));
      bus.a_pair   = W'($urandom_range(0, 2 * Q - 1));
      bus.omega    = W'($urandom_range(0, Q - 1));
      bus.mode     = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_sum"}, int'(bus.sum_out), 0);
    chk({nm, "_diff"}, int'(bus.diff_out), 0);
    chk({nm, "_tag"}, int'(bus.tag_out), 0);
    chk({nm, "_valid"}, int'(bus.out_valid), 0);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    rinv = 0;
    for (int x = 1; x < Q; x++) if ((longint'(x) * R) % Q == 1) rinv = x;

    bus.en = 1'b0; bus.in_valid = 1'b0; bus.mode = 1'b0;
    bus.a = '0; bus.a_pair = '0; bus.omega = '0; bus.tag_in = '0;

    // Asynchronous reset asserted mid-cycle.
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("reset_async");
    step();
    chk_all_zero("reset_held");
    reset_n = 1'b1;

    // Basic butterfly with omega = R mod Q, so diff reduces to d mod Q.
    drive_item(100, 30, 4075, 0, 8'h3C, 130, 70);
    chk("busy_after_accept", int'(bus.busy), 1);
    idle(8);

    // Sum wrap-around past Q.
    drive_item(5, 24000, 4075, 0, 8'h11, 11716, 583);
    idle(8);

    // Pointwise extremes.
    send(24577, 24577, 12288, 1, 8'hA5);
    drive_item(0, 5, 0, 1, 8'h5A, 5, 0);
    idle(8);

    // Back-to-back stream with a 3-cycle stall in the middle.
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        for (int k = 0; k < 3; k++) begin
          bus.en       = 1'b0;
          bus.in_valid = 1'b1;
          bus.a        = W'($urandom_range(0, 2 * Q - 1));
          bus.tag_in   = TW'($urandom_range(0, 255));
          step();
        end
      end
      send_rand(int'($urandom_range(0, 1)));
    end
    idle(8);

    // Mode interleave.
    for (int i = 0; i < 10; i++) send_rand(i % 2);
    idle(8);
    chk("drained_queue", sbq.size(), 0);
    chk("busy_idle", int'(bus.busy), 0);

    // Reset with three items in flight: none may emerge afterwards.
    for (int i = 0; i < 3; i++) send_rand(i % 2);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_midstream");
    sbq.delete();
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    idle(12);
    chk("busy_after_reset", int'(bus.busy), 0);

    // Final random tail, drained with a bounded wait.
    for (int i = 0; i < 6; i++) send_rand(int'($urandom_range(0, 1)));
    for (int i = 0; i < 50 && sbq.size() != 0; i++) idle(1);
    chk("final_drain", sbq.size(), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly_pipe.md
# ntt_butterfly_pipe

Parametrised, fully pipelined Gentleman-Sande NTT butterfly with built-in Montgomery reduction. It produces both butterfly outputs: sum = (a + a_pair) mod Q and diff = mont(omega · (a + 2Q − a_pair)). A mode input reuses the same datapath as a pointwise Montgomery multiplier. It replaces the separate add path plus multiply/reduce module in the NTT core, carries a sideband tag for coefficient/channel address, and supports a global stall.

## Interface
Parameters:
- WIDTH, 16: coefficient width; inputs and outputs.
- Q, 12289: modulus; requires 4Q < 2^WIDTH.
- R_BITS, 18: Montgomery radix exponent, R = 2^R_BITS; requires 4Q·Q < R·Q.
- QINV, 12287: −Q^−1 mod 2^R_BITS.
- TAG_W, 8: sideband tag width.

Ports:
- clk  in  1: sole clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- en  in  1: pipeline advance; low freezes every register.
- in_valid  in  1: input operands valid this cycle (sampled only when en=1).
- mode  in  1: 0 = butterfly, 1 = pointwise multiply.
- a  in  WIDTH: operand, range [0, 2Q).
- a_pair  in  WIDTH: operand, range [0, 2Q).
- omega  in  WIDTH: twiddle or multiplicand, range [0, Q).
- tag_in  in  TAG_W: sideband, passed through aligned.
- sum_out  out  WIDTH: [0, Q).
- diff_out  out  WIDTH: [0, Q).
- tag_out  out  TAG_W: aligned with the outputs.
- out_valid  out  1: outputs valid.
- busy  out  1: a valid item is in stages 1–4, or out_valid is high.

## Operation
- Stage 1 (S1) registers the pre-adders:
  - mode 0: d = a + 2Q − a_pair, range (0, 4Q); s = a + a_pair.
  - mode 1: d = a; s = a_pair.
- Stage 1 also reduces s to [0, Q): subtract 2Q if s ≥ 2Q, then subtract Q if the result is ≥ Q. This step sits in stage 1 or stage 2.
- S2: T = d · omega, with full width 2·WIDTH.
- S3: m = (T mod 2^R_BITS) · QINV mod 2^R_BITS. Register T alongside.
- S4: u = T + m·Q; low R_BITS are zero by construction.
- S5: t = u >> R_BITS, which is < 2Q. Output t − Q if t ≥ Q, else t, into diff_out.
- sum, tag and valid move through delay registers matched to stage 5. sum_out, diff_out and tag_out all update in the same cycle as out_valid.
- Each stage carries a valid bit. Data registers load every enabled cycle regardless of valid. Outputs are don't-care when out_valid=0; verification checks them only when out_valid=1.
- Out-of-range inputs (a or a_pair ≥ 2Q, or omega ≥ Q) are undefined behaviour. The block does not check or saturate them.

## Timing
- Latency is 5 enabled cycles. An item accepted at rising edge k (en=1, in_valid=1) gives out_valid=1 after edge k+4, so it is visible during cycle k+5. Cycles with en=0 add to the latency one for one.
- Throughput is 1 item per enabled cycle. There is no back-pressure beyond en.
- With en=0, all data, valid and tag registers hold. out_valid stays at its current level, so a valid output persists across a stall.
- When reset_n falls, it clears immediately, regardless of clk: all valid bits, out_valid, busy, sum_out, diff_out and tag_out to 0. Internal data registers may also be cleared.
- Reset release is synchronised externally. The first sample is taken at the first rising edge with reset_n=1 and en=1.
- Reset mid-stream discards every in-flight item; none of them emerge after reset.
- busy is combinational OR of the valid bits in S1–S4 and out_valid. It is low one cycle after the last item's out_valid cycle, provided no new item entered.
- mode may change on every item; each item's mode travels with it.

## Test plan
- Reset and basic butterfly:
  - Stimulus: assert reset_n=0 mid-cycle, release, then apply a=100, a_pair=30, omega=4075 (R mod Q), tag=0x3C, mode 0.
  - Required response: all outputs are 0 while reset_n=0. Exactly 5 cycles after acceptance: sum_out=130, diff_out=70, tag_out=0x3C, and out_valid pulses 1 cycle.
- Wrap-around:
  - Stimulus: a=5, a_pair=24000, omega=4075, mode 0.
  - Required response: sum_out=11716, diff_out=583.
- Back-to-back stream and stall:
  - Stimulus: 16 consecutive random in-range items, with en dropped for 3 cycles mid-stream.
  - Required response: outputs match a golden model in order with tags intact. Nothing is lost or duplicated. out_valid holds during the stall. Total latency per item is 5 plus the stall cycles.
- Pointwise mode and extremes:
  - Stimulus: mode 1 with a=24577, omega=12288, a_pair=24577. Also mode 1 with a=0, omega=0.
  - Required response: diff_out equals the model value a·omega·R^−1 mod Q, which is < Q; sum_out=12288. For the zero case, diff_out=0.
- Reset mid-operation:
  - Stimulus: 3 items in flight, then pulse reset_n low.
  - Required response: out_valid and busy drop immediately, and none of the 3 items ever appears at the output.
- Mode interleave:
  - Stimulus: alternate mode 0 and mode 1 every cycle for 10 items.
  - Required response: each output matches its own item's mode in the model.
